// File: rtl/ripple_carry_adder_4b_pkg.sv
// Shared types for the 4-bit ripple-carry adder.
// Holds the operand width and the registered result bundle.
package ripple_carry_adder_4b_pkg;

  localparam int RCA_WIDTH = 4;

  typedef struct packed {
    logic [RCA_WIDTH-1:0] sum;
    logic                 cout;
    logic                 ovf;
  } rca_res_t;

endpackage

// File: rtl/ripple_carry_adder_4b_if.sv
// Operand/result bundle for the 4-bit ripple-carry adder.
// The master drives operands; the slave returns the results.
interface ripple_carry_adder_4b_if;
  import ripple_carry_adder_4b_pkg::*;

  logic [RCA_WIDTH-1:0] a;
  logic [RCA_WIDTH-1:0] b;
  logic                 cin;
  logic [RCA_WIDTH-1:0] sum;
  logic                 cout;
  logic [RCA_WIDTH-1:0] sum_q;
  logic                 cout_q;
  logic                 ovf_q;

  modport master (
    output a, b, cin,
    input  sum, cout,
    input  sum_q, cout_q, ovf_q
  );

  modport slave (
    input  a, b, cin,
    output sum, cout,
    output sum_q, cout_q, ovf_q
  );

endinterface

// File: rtl/ripple_carry_adder_4b_fa.sv
// One-bit full adder cell.
// Chained by the 4-bit adder to form the ripple carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of a single bit position.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_carry_adder_4b.sv
// 4-bit ripple-carry adder with registered result.
// Combinational sum/cout plus sum_q/cout_q/ovf_q flops.
module ripple_carry_adder_4b
  import ripple_carry_adder_4b_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  logic [WIDTH:0] c;
  rca_res_t       res_d;
  rca_res_t       res_q;

  assign c[0] = cin;

  // Carry chain: bit i consumes c[i] and produces c[i+1].
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[WIDTH];

  // Signed overflow is the carry into vs. out of the sign bit.
  always_comb begin
    res_d      = '0;
    res_d.sum  = sum;
    res_d.cout = cout;
    res_d.ovf  = c[WIDTH-1] ^ c[WIDTH];
  end

  // Capture the result; reset clears it without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign sum_q  = res_q.sum;
  assign cout_q = res_q.cout;
  assign ovf_q  = res_q.ovf;

endmodule

// File: tb/tb_ripple_carry_adder_4b.sv
// Self-checking bench for ripple_carry_adder_4b.
// Random and directed stimulus against an arithmetic model.
module tb_ripple_carry_adder_4b;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  ripple_carry_adder_4b_if bus ();

  ripple_carry_adder_4b dut (
    .a      (bus.a),
    .b      (bus.b),
    .cin    (bus.cin),
    .sum    (bus.sum),
    .cout   (bus.cout),
    .clk    (clk),
    .rst_n  (rst_n),
    .sum_q  (bus.sum_q),
    .cout_q (bus.cout_q),
    .ovf_q  (bus.ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ref_add(
    input logic [3:0] a, input logic [3:0] b,
    input logic ci
  );
    int t;
    t = int'(a) + int'(b) + int'(ci);
    return t[4:0];
  endfunction

  function automatic logic ref_ovf(
    input logic [3:0] a, input logic [3:0] b,
    input logic ci
  );
    int t;
    t = int'($signed(a)) + int'($signed(b)) + int'(ci);
    return (t > 7) || (t < -8);
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.a   = 4'd9;
    bus.b   = 4'd9;
    bus.cin = 1'b1;
    #2;
    checks++;
    if ({bus.sum_q, bus.cout_q, bus.ovf_q} !== 6'd0)
      $display("FAIL reset_regs got=%b exp=000000",
               {bus.sum_q, bus.cout_q, bus.ovf_q});
    else passed++;
    checks++;
    if ({bus.cout, bus.sum} !== ref_add(4'd9, 4'd9, 1'b1))
      $display("FAIL reset_comb got=%b exp=%b",
               {bus.cout, bus.sum}, ref_add(4'd9, 4'd9, 1'b1));
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.sum_q, bus.cout_q, bus.ovf_q} !== 6'd0)
      $display("FAIL reset_hold got=%b exp=000000",
               {bus.sum_q, bus.cout_q, bus.ovf_q});
    else passed++;
  endtask

  task automatic test_sweep();
    int errs;
    logic [4:0] exp;
    for (int ci = 0; ci < 2; ci++) begin
      errs = 0;
      for (int v = 0; v < 256; v++) begin
        bus.cin = ci[0];
        bus.a   = v[7:4];
        bus.b   = v[3:0];
        #1;
        exp = ref_add(v[7:4], v[3:0], ci[0]);
        if ({bus.cout, bus.sum} !== exp) begin
          errs++;
          if (errs < 4)
            $display("FAIL sweep a=%h b=%h ci=%0d got=%b exp=%b",
                     v[7:4], v[3:0], ci, {bus.cout, bus.sum}, exp);
        end
        #4;
      end
      checks++;
      if (errs == 0) passed++;
    end
  endtask

  task automatic test_random();
    logic [3:0] pa, pb;
    logic       pc;
    logic [4:0] exp;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      pa = 4'($urandom);
      pb = 4'($urandom);
      pc = 1'($urandom);
      bus.a = pa; bus.b = pb; bus.cin = pc;
      #1;
      exp = ref_add(pa, pb, pc);
      checks++;
      if ({bus.cout, bus.sum} !== exp)
        $display("FAIL rand_comb got=%b exp=%b",
                 {bus.cout, bus.sum}, exp);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.cout_q, bus.sum_q, bus.ovf_q} !==
          {exp, ref_ovf(pa, pb, pc)})
        $display("FAIL rand_reg got=%b exp=%b",
                 {bus.cout_q, bus.sum_q, bus.ovf_q},
                 {exp, ref_ovf(pa, pb, pc)});
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic corner(
    input logic [3:0] ca, input logic [3:0] cb,
    input logic cc, input logic [3:0] es,
    input logic ec, input logic eo
  );
    @(negedge clk);
    bus.a = ca; bus.b = cb; bus.cin = cc;
    #1;
    checks++;
    if ({bus.cout, bus.sum} !== {ec, es})
      $display("FAIL corner_comb a=%b b=%b got=%b exp=%b",
               ca, cb, {bus.cout, bus.sum}, {ec, es});
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.sum_q, bus.cout_q, bus.ovf_q} !== {es, ec, eo})
      $display("FAIL corner_reg a=%b b=%b got=%b exp=%b",
               ca, cb, {bus.sum_q, bus.cout_q, bus.ovf_q},
               {es, ec, eo});
    else passed++;
  endtask

  task automatic test_corners();
    corner(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    corner(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
    corner(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
    corner(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.a = 4'b0111; bus.b = 4'b0111; bus.cin = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.sum_q, bus.cout_q, bus.ovf_q} !== 6'b1111_0_1)
      $display("FAIL preload got=%b exp=111101",
               {bus.sum_q, bus.cout_q, bus.ovf_q});
    else passed++;
    #2;
    rst_n = 1'b0;
    #0.5;
    checks++;
    if ({bus.sum_q, bus.cout_q, bus.ovf_q} !== 6'd0)
      $display("FAIL async_clear got=%b exp=000000",
               {bus.sum_q, bus.cout_q, bus.ovf_q});
    else passed++;
    checks++;
    if ({bus.cout, bus.sum} !== 5'b0_1111)
      $display("FAIL async_comb got=%b exp=01111",
               {bus.cout, bus.sum});
    else passed++;
  endtask

  task automatic test_release();
    @(negedge clk);
    bus.a = 4'b0101; bus.b = 4'b0011; bus.cin = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.sum_q, bus.cout_q} !== 5'b1000_0)
      $display("FAIL release got=%b exp=10000",
               {bus.sum_q, bus.cout_q});
    else passed++;
    checks++;
    if (bus.ovf_q !== ref_ovf(4'b0101, 4'b0011, 1'b0))
      $display("FAIL release_ovf got=%b exp=%b", bus.ovf_q,
               ref_ovf(4'b0101, 4'b0011, 1'b0));
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_sweep();
    test_random();
    test_corners();
    test_async_reset();
    test_release();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
